// File: rtl/cam_capture_ctrl.sv
// cam_capture_ctrl: one-frame camera capture sequencer with a FIFO write side
// and a valid/ready drain side. The optional frame counter output o_frame_cnt
// is built only when CAM_FRAME_CNT_EN is defined.
module cam_capture_ctrl #(
  parameter int DW        = 8,
  parameter int BCNT_W    = 11,
  parameter int LCNT_W    = 10,
  parameter int EXP_BYTES = 1280,
  parameter int EXP_LINES = 480
) (
  input  logic          i_pclk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic          i_abort,
  input  logic          i_cam_vsync,
  input  logic          i_cam_href,
  input  logic [DW-1:0] i_cam_data,
  input  logic          i_fifo_full,
  input  logic          i_fifo_empty,
  input  logic [DW-1:0] i_fifo_dout,
  output logic          o_fifo_wr,
  output logic          o_fifo_rd,
  output logic [DW-1:0] o_fifo_din,
  output logic [DW-1:0] o_out_data,
  output logic          o_out_valid,
  input  logic          i_out_ready,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_ovf,
`ifdef CAM_FRAME_CNT_EN
  output logic [15:0]   o_frame_cnt,
`endif
  output logic          o_frame_err
);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_SYNC, S_CAPTURE, S_FLUSH} state_t;

  localparam logic [BCNT_W-1:0] L_EXP_B = BCNT_W'(EXP_BYTES);
  localparam logic [LCNT_W-1:0] L_EXP_L = LCNT_W'(EXP_LINES);

  state_t              r_state;
  logic                r_vs_d, r_href_d;
  logic [BCNT_W-1:0]   r_bcnt;
  logic [LCNT_W-1:0]   r_lcnt;
  logic                r_done, r_ovf, r_err;
  logic [DW-1:0]       r_out_data;
  logic                r_out_valid;

  logic                w_vs_rise, w_vs_fall, w_href_fall, w_cap, w_flush_done, w_fifo_rd;
  logic [BCNT_W-1:0]   w_bcnt_inc;
  logic [LCNT_W-1:0]   w_lcnt_inc, w_lcnt_eff;

  assign w_vs_rise    = i_cam_vsync & ~r_vs_d;
  assign w_vs_fall    = ~i_cam_vsync & r_vs_d;
  assign w_href_fall  = ~i_cam_href & r_href_d;
  assign w_cap        = (r_state == S_CAPTURE);
  assign w_bcnt_inc   = (&r_bcnt) ? r_bcnt : r_bcnt + 1'b1;
  assign w_lcnt_inc   = (&r_lcnt) ? r_lcnt : r_lcnt + 1'b1;
  // a line closing on the same edge vsync rises still counts toward the frame
  assign w_lcnt_eff   = w_href_fall ? w_lcnt_inc : r_lcnt;
  assign w_flush_done = (r_state == S_FLUSH) & ~i_abort & i_fifo_empty & ~r_out_valid;

  // gated by reset so nothing leaks to the FIFO while the block is held in reset
  assign o_fifo_wr   = w_cap & i_cam_href & ~i_fifo_full;
  assign o_fifo_din  = i_rst ? i_cam_data : '0;
  assign w_fifo_rd   = i_rst & ~i_fifo_empty & (~r_out_valid | i_out_ready);
  assign o_fifo_rd   = w_fifo_rd;
  assign o_out_data  = r_out_data;
  assign o_out_valid = r_out_valid;
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = r_done;
  assign o_ovf       = r_ovf;
  assign o_frame_err = r_err;

  // frame sequencer, geometry counters and sticky status flags
  always_ff @(posedge i_pclk or negedge i_rst) begin
    if (!i_rst) begin
      r_state  <= S_IDLE;
      r_vs_d   <= 1'b0;
      r_href_d <= 1'b0;
      r_bcnt   <= '0;
      r_lcnt   <= '0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_vs_d   <= i_cam_vsync;
      r_href_d <= i_cam_href;
      r_done   <= 1'b0;
      if (i_abort) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: if (i_start) begin
            r_state <= S_ARM;
            r_ovf   <= 1'b0;
            r_err   <= 1'b0;
            r_bcnt  <= '0;
            r_lcnt  <= '0;
          end
          S_ARM:  if (w_vs_rise) r_state <= S_SYNC;
          S_SYNC: if (w_vs_fall) r_state <= S_CAPTURE;
          S_CAPTURE: begin
            if (i_cam_href) begin
              // dropped bytes still count toward line length
              r_bcnt <= w_bcnt_inc;
              if (i_fifo_full) r_ovf <= 1'b1;
            end else if (w_href_fall) begin
              if (r_bcnt != L_EXP_B) r_err <= 1'b1;
              r_bcnt <= '0;
              r_lcnt <= w_lcnt_inc;
            end
            if (w_vs_rise) begin
              r_state <= S_FLUSH;
              // an open line at frame end is not counted and is an error
              if (i_cam_href || (w_lcnt_eff != L_EXP_L)) r_err <= 1'b1;
            end
          end
          S_FLUSH: if (w_flush_done) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // one-entry output register: refilled from the FIFO whenever empty or being taken
  always_ff @(posedge i_pclk or negedge i_rst) begin
    if (!i_rst) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else if (w_fifo_rd) begin
      r_out_data  <= i_fifo_dout;
      r_out_valid <= 1'b1;
    end else if (r_out_valid && i_out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

`ifdef CAM_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;
  assign o_frame_cnt = r_frame_cnt;

  // completed-frame counter; aborted frames never reach the done transition
  always_ff @(posedge i_pclk or negedge i_rst) begin
    if (!i_rst)            r_frame_cnt <= '0;
    else if (w_flush_done) r_frame_cnt <= r_frame_cnt + 16'd1;
  end
`endif

endmodule
